// File: rtl/router_3x1_4bit_merge.sv
// router_3x1_4bit_merge: three per-source FIFOs merged round-robin onto one tagged valid/ready output
module router_3x1_4bit_merge #(
   parameter int DATA_W = 4,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in0,
   input  logic [DATA_W-1:0] in1,
   input  logic [DATA_W-1:0] in2,
   input  logic              valid_in0,
   input  logic              valid_in1,
   input  logic              valid_in2,
   output logic              ready0,
   output logic              ready1,
   output logic              ready2,
   output logic [DATA_W-1:0] data_out,
   output logic [1:0]        src_out,
   output logic              valid_out,
   input  logic              ready_in,
   output logic [2:0]        ovf
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [DATA_W-1:0] din [3];
   logic [DATA_W-1:0] mem [3][DEPTH];
   logic [AW-1:0]     wr_ptr [3];
   logic [AW-1:0]     rd_ptr [3];
   logic [CW-1:0]     cnt [3];
   logic [2:0]        vin, rdy, ne, push, pop;
   logic [1:0]        last_grant, grant, c1, c2;
   logic              any_ne, load;

   assign din[0] = in0;
   assign din[1] = in1;
   assign din[2] = in2;
   assign vin = {valid_in2, valid_in1, valid_in0};
   assign {ready2, ready1, ready0} = rdy;
   assign any_ne = |ne;
   assign load = (!valid_out || ready_in) && any_ne;

   for (genvar i = 0; i < 3; i++) begin : g_port
      assign rdy[i]  = !rst && (cnt[i] != FULL);
      assign ne[i]   = cnt[i] != '0;
      assign push[i] = vin[i] && rdy[i];
      assign pop[i]  = load && (grant == 2'(i));
   end

   // round-robin search starting just after the last granted source
   always_comb begin
      c1    = (last_grant == 2'd2) ? 2'd0 : last_grant + 2'd1;
      c2    = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;
      grant = ne[c1] ? c1 : ne[c2] ? c2 : last_grant;
   end

   // per-source FIFO storage, pointers, occupancy and sticky overflow
   always_ff @(posedge clk) begin
      for (int n = 0; n < 3; n++) begin
         if (rst) begin
            cnt[n]    <= '0;
            wr_ptr[n] <= '0;
            rd_ptr[n] <= '0;
            ovf[n]    <= 1'b0;
         end else begin
            if (push[n]) begin
               mem[n][wr_ptr[n]] <= din[n];
               wr_ptr[n]         <= wr_ptr[n] + AW'(1);
            end
            if (pop[n]) rd_ptr[n] <= rd_ptr[n] + AW'(1);
            cnt[n] <= cnt[n] + CW'(push[n]) - CW'(pop[n]);
            if (vin[n] && !rdy[n]) ovf[n] <= 1'b1;
         end
      end
   end

   // registered output stage: load the granted head whenever the slot is free or being taken
   always_ff @(posedge clk) begin
      if (rst) begin
         data_out   <= '0;
         src_out    <= 2'd0;
         valid_out  <= 1'b0;
         last_grant <= 2'd2;
      end else if (!valid_out || ready_in) begin
         valid_out <= any_ne;
         if (any_ne) begin
            data_out   <= mem[grant][rd_ptr[grant]];
            src_out    <= grant;
            last_grant <= grant;
         end
      end
   end
endmodule

// File: tb/tb_router_3x1_4bit_merge.sv
// tb_router_3x1_4bit_merge: queue-based reference model plus directed scenarios for the 3x1 merger
module tb_router_3x1_4bit_merge;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] in0 = '0, in1 = '0, in2 = '0;
   logic       valid_in0 = 1'b0, valid_in1 = 1'b0, valid_in2 = 1'b0;
   logic       ready_in = 1'b0;
   logic       ready0, ready1, ready2, valid_out;
   logic [3:0] data_out;
   logic [1:0] src_out;
   logic [2:0] ovf;

   int tests = 0;
   int fails = 0;

   logic [3:0] q [3][$];
   logic       m_valid = 1'b0;
   logic [3:0] m_data = '0;
   logic [1:0] m_src = '0;
   int         m_last = 2;
   logic [2:0] m_ovf = '0;

   router_3x1_4bit_merge #(.DATA_W(4), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .in0(in0), .in1(in1), .in2(in2),
      .valid_in0(valid_in0), .valid_in1(valid_in1), .valid_in2(valid_in2),
      .ready0(ready0), .ready1(ready1), .ready2(ready2),
      .data_out(data_out), .src_out(src_out), .valid_out(valid_out),
      .ready_in(ready_in), .ovf(ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // reference model: per-source queues, pop decided on pre-edge occupancy, then pushes
   always @(posedge clk) begin
      int sz [3];
      int g;
      logic [3:0] d [3];
      logic [2:0] v;
      d[0] = in0; d[1] = in1; d[2] = in2;
      v = {valid_in2, valid_in1, valid_in0};
      if (rst) begin
         for (int n = 0; n < 3; n++) q[n].delete();
         m_valid = 1'b0; m_data = '0; m_src = '0; m_last = 2; m_ovf = '0;
      end else begin
         for (int n = 0; n < 3; n++) sz[n] = q[n].size();
         if (!m_valid || ready_in) begin
            g = -1;
            for (int i = 1; i <= 3; i++)
               if (g < 0 && sz[(m_last + i) % 3] > 0) g = (m_last + i) % 3;
            if (g >= 0) begin
               m_data = q[g].pop_front();
               m_src = 2'(g);
               m_valid = 1'b1;
               m_last = g;
            end else m_valid = 1'b0;
         end
         for (int n = 0; n < 3; n++)
            if (v[n]) begin
               if (sz[n] != DEPTH) q[n].push_back(d[n]);
               else m_ovf[n] = 1'b1;
            end
      end
   end

   // every-cycle comparison of all outputs against the model, mid-cycle
   always @(negedge clk) begin
      logic [2:0] mr;
      for (int n = 0; n < 3; n++) mr[n] = !rst && (q[n].size() != DEPTH);
      chk("cycle", 16'({valid_out, data_out, src_out, ovf, ready2, ready1, ready0}),
                   16'({m_valid, m_data, m_src, m_ovf, mr}));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_valid();
      valid_in0 = 1'b0; valid_in1 = 1'b0; valid_in2 = 1'b0;
   endtask

   task automatic do_rst();
      clr_valid();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   logic [6:0] exp_rr [5] = '{{1'b1, 4'h2, 2'd1}, {1'b1, 4'h3, 2'd2}, {1'b1, 4'h4, 2'd0},
                              {1'b1, 4'h5, 2'd1}, {1'b1, 4'h6, 2'd2}};

   initial begin
      // reset to single word
      rst = 1'b1; valid_in0 = 1'b1; in0 = 4'hF;
      tick(); tick();
      chk("rst_ready", 16'({ready2, ready1, ready0}), 16'h0);
      rst = 1'b0; valid_in0 = 1'b0;
      tick();
      chk("post_rst", 16'({valid_out, ovf}), 16'h0);
      in1 = 4'hA; valid_in1 = 1'b1; ready_in = 1'b1;
      tick();
      valid_in1 = 1'b0;
      chk("latency", 16'(valid_out), 16'h0);
      tick();
      chk("single", 16'({valid_out, data_out, src_out}), 16'({1'b1, 4'hA, 2'd1}));
      tick();
      chk("single_end", 16'(valid_out), 16'h0);

      // round-robin
      do_rst();
      in0 = 4'h1; in1 = 4'h2; in2 = 4'h3;
      valid_in0 = 1'b1; valid_in1 = 1'b1; valid_in2 = 1'b1;
      tick();
      in0 = 4'h4; in1 = 4'h5; in2 = 4'h6;
      tick();
      clr_valid();
      chk("rr0", 16'({valid_out, data_out, src_out}), 16'({1'b1, 4'h1, 2'd0}));
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("rr", 16'({valid_out, data_out, src_out}), 16'(exp_rr[i]));
      end
      tick();
      chk("rr_end", 16'(valid_out), 16'h0);

      // backpressure with overflow on source 0
      do_rst();
      ready_in = 1'b0;
      in2 = 4'h7; valid_in2 = 1'b1;
      tick();
      valid_in2 = 1'b0;
      tick();
      chk("bp_load", 16'({valid_out, data_out, src_out}), 16'({1'b1, 4'h7, 2'd2}));
      for (int i = 0; i < 5; i++) begin
         in0 = 4'(8 + i); valid_in0 = 1'b1;
         chk("bp_ready0", 16'(ready0), 16'(i < 4));
         tick();
         chk("bp_stall", 16'({valid_out, data_out, src_out}), 16'({1'b1, 4'h7, 2'd2}));
      end
      valid_in0 = 1'b0;
      chk("bp_ovf", 16'(ovf), 16'h1);
      ready_in = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("bp_drain", 16'({valid_out, data_out, src_out}), 16'({1'b1, 4'(8 + i), 2'd0}));
      end
      tick();
      chk("bp_dropped", 16'(valid_out), 16'h0);

      // FIFO pointer wrap through source 1
      do_rst();
      ready_in = 1'b1;
      for (int i = 0; i < 12; i++) begin
         in1 = 4'(i); valid_in1 = 1'b1;
         tick();
         if (i > 0) chk("wrap", 16'({valid_out, data_out, src_out}), 16'({1'b1, 4'(i - 1), 2'd1}));
      end
      valid_in1 = 1'b0;
      tick();
      chk("wrap_last", 16'({valid_out, data_out, src_out, ovf}), 16'({1'b1, 4'hB, 2'd1, 3'b000}));
      tick();

      // full FIFO with simultaneous push and pop
      do_rst();
      ready_in = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         in2 = 4'(i); valid_in2 = 1'b1;
         tick();
      end
      chk("full_ready2", 16'(ready2), 16'h0);
      chk("full_out", 16'({valid_out, data_out, src_out}), 16'({1'b1, 4'h1, 2'd2}));
      ready_in = 1'b1; in2 = 4'hF;
      tick();
      valid_in2 = 1'b0;
      chk("full_ovf", 16'(ovf), 16'h4);
      chk("full_ready_back", 16'(ready2), 16'h1);
      chk("full_pop", 16'({valid_out, data_out, src_out}), 16'({1'b1, 4'h2, 2'd2}));
      for (int i = 0; i < 4; i++) tick();

      // mid-stream reset
      do_rst();
      ready_in = 1'b0;
      in0 = 4'h1; in1 = 4'h2; in2 = 4'h3;
      valid_in0 = 1'b1; valid_in1 = 1'b1; valid_in2 = 1'b1;
      tick();
      clr_valid();
      tick();
      chk("mid_loaded", 16'({valid_out, data_out, src_out}), 16'({1'b1, 4'h1, 2'd0}));
      rst = 1'b1;
      tick();
      chk("mid_rst", 16'({valid_out, data_out, ovf}), 16'h0);
      rst = 1'b0; ready_in = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("no_stale", 16'(valid_out), 16'h0);
      end

      tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/router_3x1_4bit_merge.md
Name: router_3x1_4bit_merge

Overview:
- Return-path merger for the 1x3 router. Collects 4-bit words from three source ports and serialises them onto one output channel.
- Each source has its own small FIFO. A round-robin arbiter drains the FIFOs into a registered output stage that uses a valid/ready handshake.
- The output carries a 2-bit source tag, so the downstream 1x3 router can steer replies back on the sel lines.

Parameters:
- DATA_W, 4, width of every data path.
- DEPTH, 4, entries per input FIFO. Must be a power of 2 and at least 2.

Ports:
- clk  input  1  rising-edge clock for all state.
- rst  input  1  synchronous, active-high reset.
- in0, in1, in2  input  DATA_W  per-source data.
- valid_in0, valid_in1, valid_in2  input  1  source N presents a word.
- ready0, ready1, ready2  output  1  FIFO N can accept a word.
- data_out  output  DATA_W  merged output word.
- src_out  output  2  source index of data_out (0, 1 or 2; never 3).
- valid_out  output  1  data_out/src_out hold a valid word.
- ready_in  input  1  sink accepts the word this cycle.
- ovf  output  3  sticky per-source overflow flags.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst, sampled only at posedge clk.
- Reset values: data_out=0, src_out=0, valid_out=0, ovf=3'b000. All FIFO counts, read pointers and write pointers are 0. last_grant=2, so the first arbitration order is 0, 1, 2.
- Ready during reset: while rst=1, ready0..2 are forced to 0 and all valid_in are ignored.
- Reset mid-operation: all buffered words and the output register are discarded. No partial state survives.
- ready generation: readyN = !rst && (countN != DEPTH). It is combinational from the registered count only, with no pop-bypass. A full FIFO that is popped this cycle still shows readyN=0.
- Push: when valid_inN && readyN at a clk edge, inN is written at wr_ptrN, wr_ptrN advances (wraps mod DEPTH) and countN increments.
- Overflow: when valid_inN && !readyN (rst=0), the word is dropped and ovf[N] is set. ovf[N] stays set until rst.
- Output load condition: the output register loads when (!valid_out || ready_in) and at least one FIFO is non-empty.
- Output load action: data_out gets the head of the granted FIFO and src_out gets its index. valid_out goes to 1, the granted FIFO pops (rd_ptr advances with wrap, count decrements) and last_grant updates to the granted index.
- Output idle: if the load condition holds but all FIFOs are empty, valid_out goes to 0. data_out and src_out keep their last values.
- Output stall: when valid_out=1 and ready_in=0, data_out, src_out and valid_out stay stable. No pop occurs and last_grant is unchanged.
- Arbitration: the grant is the first non-empty FIFO searching last_grant+1, last_grant+2, last_grant+3 (all mod 3). last_grant changes only on a pop.
- Push and pop on the same FIFO in one cycle: count is unchanged and both pointers advance.
- Latency: a word pushed into an empty FIFO at edge k, with the output free, appears with valid_out=1 after edge k+1. There is no same-cycle bypass from in to data_out.
- Throughput: one word per cycle while ready_in=1 and any FIFO is non-empty.
- Ordering: order is preserved per source. There is no ordering guarantee between sources beyond round-robin.
- Width rules: counts are log2(DEPTH)+1 bits and pointers are log2(DEPTH) bits.

Test Plan:
- Reset to single word: hold rst=1 for 2 cycles with valid_in0=1, in0=4'hF. Required: no push, ready0..2=0, and after release valid_out=0, ovf=0. Then push in1=4'hA once with ready_in=1. Required: after the next edge, data_out=4'hA, src_out=1, valid_out=1 for exactly one cycle.
- Round-robin: push 0x1, 0x2, 0x3 into sources 0, 1, 2 in the same cycle, then 0x4, 0x5, 0x6 the next cycle, with ready_in=1. Required output sequence (data/src): 1/0, 2/1, 3/2, 4/0, 5/1, 6/2 on consecutive cycles.
- Backpressure: hold ready_in=0 with valid_out=1, data_out=0x7, src_out=2 for 5 cycles while pushing into source 0. Required: outputs stable for all 5 cycles. ready0 drops after DEPTH=4 pushes. The fifth push sets ovf[0]=1 and is never output.
- FIFO wrap: stream 12 words 0x0..0xB through source 1 alone with ready_in=1. Required: the same 12 words in order with src_out=1, and ovf=0.
- Full simultaneous push/pop: with FIFO2 full (4 words) and ready_in=1, drive valid_in2=1. Required: ready2=0 in the pop cycle, the word is dropped, and ovf[2]=1. The next cycle ready2=1.
- Mid-stream reset: with 3 words buffered across sources and valid_out=1, assert rst for 1 cycle. Required: after the edge, valid_out=0, data_out=0, ovf=0. No stale word ever appears afterwards.
